// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store unit in front of a word-only
// memory. The memory has no byte enables, so sub-word stores are performed
// as a read-modify-write of the containing word.
// Build option: define MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into errors; otherwise the ignored low address bits read as zero.
//
// Handshake: a request is accepted on a posedge where req_valid & req_ready;
// req_ready is high only in IDLE and all req_* fields are captured then.
// resp_valid is a one-cycle pulse with no back-pressure; resp_rdata and
// resp_err are meaningful only while it is high and read as 0 otherwise.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        DATA = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    // Holds store data from acceptance, then the load result / merged word.
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        illegal_f3;
    logic        out_of_range;
    logic        misalign;
    logic        req_bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] loaded;
    logic [31:0] merged;
    logic [31:0] word_addr;

    assign word_addr = {addr_q[31:2], 2'b00};
    assign dbg_state = state_q;

    // Classify the incoming request: legal funct3, in-range word, alignment.
    always_comb begin
        illegal_f3 = 1'b1;
        case (req_f3)
            3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
            3'b100, 3'b101:         illegal_f3 = req_we;
            default:                illegal_f3 = 1'b1;
        endcase
        out_of_range = {1'b0, req_addr[31:2]} >= MEM_LIMIT;
`ifdef MISALIGN_TRAP_EN
        misalign = ((req_f3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_bad = illegal_f3 | out_of_range | misalign;
    end

    // Load extraction from the read word, sign or zero extended by funct3.
    always_comb begin
        byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  loaded = {{24{byte_v[7]}}, byte_v};
            3'b001:  loaded = {{16{half_v[15]}}, half_v};
            3'b100:  loaded = {24'd0, byte_v};
            3'b101:  loaded = {16'd0, half_v};
            default: loaded = mem_rdata;
        endcase
    end

    // Store merge: replace only the addressed byte or half of the read word.
    always_comb begin
        merged = mem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
    end

    // Next-state and output decode; outputs depend on state only.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d   = req_we;
                    f3_d   = req_f3;
                    addr_d = req_addr;
                    data_d = req_wdata;
                    err_d  = req_bad;
                    if (req_bad) begin
                        data_d  = 32'd0;
                        state_d = RESP;
                    end else if (req_we && (req_f3 == 3'b010)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_addr = word_addr;
                state_d  = DATA;
            end
            DATA: begin
                if (we_q) begin
                    data_d  = merged;
                    state_d = WR;
                end else begin
                    data_d  = loaded;
                    state_d = RESP;
                end
            end
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = data_q;
                data_d    = 32'd0;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = data_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, 256, number of 32-bit words in the attached memory; word index >= MEM_WORDS is out of range.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  1  core requests an access.
REQ-005 Port: req_ready  output  1  unit accepts a request this cycle.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_f3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  store data, right-aligned.
REQ-010 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-011 Port: resp_rdata  output  32  aligned, extended load result; 0 for stores and errors.
REQ-012 Port: resp_err  output  1  access rejected; qualified by resp_valid.
REQ-013 Port: mem_we  output  1  word write strobe to the memory.
REQ-014 Port: mem_addr  output  32  byte address to the memory, bits [1:0] = 00.
REQ-015 Port: mem_wdata  output  32  full word to write.
REQ-016 Port: mem_rdata  input  32  memory read word, valid one cycle after mem_addr is presented.

Function
REQ-017 The memory has no byte enables, so the unit SHALL perform every sb/sh as a read-modify-write of the whole word.
REQ-018 FSM states: IDLE, RD, DATA, WR, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid & req_ready, and all req_* fields are registered on acceptance.
REQ-020 Load path SHALL be IDLE -> RD -> DATA -> RESP, with resp_valid high on the 3rd posedge after acceptance.
REQ-021 Store-word path SHALL be IDLE -> WR -> RESP.
REQ-022 Store byte/half path SHALL be IDLE -> RD -> DATA -> WR -> RESP.
REQ-023 Error path SHALL be IDLE -> RESP with resp_err = 1 and no memory read or write.
REQ-024 Behaviour by state, with mem_addr = {addr[31:2], 2'b00} in RD and WR:
- RD: mem_we = 0.
- DATA: capture mem_rdata, then extract (loads) or merge (stores).
- WR: mem_we = 1 for exactly one cycle.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
REQ-025 Load extraction:
- byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16].
- lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
REQ-026 Store merge SHALL replace only the addressed byte or half with req_wdata[7:0] or [15:0] and keep all other bytes from the read word.
REQ-027 Illegal funct3 (011, 110, 111, or any 1xx with req_we = 1) SHALL set resp_err.
REQ-028 A word index >= MEM_WORDS SHALL set resp_err.
REQ-029 mem_we SHALL be 0 in every state except WR.
REQ-030 resp_rdata and resp_err SHALL be held stable while resp_valid = 1 and SHALL be 0 otherwise.
REQ-031 req_valid asserted in a non-IDLE state SHALL be ignored, and the core SHALL hold it until accepted.

Reset
REQ-032 On reset, the unit SHALL go to IDLE with all registered outputs 0 and req_ready 1 from the first cycle after reset deasserts.
REQ-033 Reset asserted mid-operation SHALL abort the access with no resp_valid and mem_we = 0 from the next cycle; a write already strobed in WR is not undone.

Configuration
REQ-034 With MISALIGN_TRAP_EN defined, a halfword access with addr[0] = 1 or a word access with addr[1:0] != 00 SHALL take the error path.
REQ-035 With MISALIGN_TRAP_EN undefined, ignored low bits SHALL be treated as zero (half uses addr[1]; word uses addr[31:2]) and the access SHALL complete without error.

Verification
REQ-036 Memory word 0x40 = 0x8877_6655; lb at 0x43 -> resp_rdata 0xFFFF_FF88, resp_valid exactly 3 cycles after accept.
REQ-037 Same word; lhu at 0x42 -> 0x0000_8877; lh at 0x40 -> 0x0000_6655.
REQ-038 Same word; sb 0xAB at 0x41 -> one mem_we pulse writing 0x8877_AB55, then lw at 0x40 returns 0x8877_AB55.
REQ-039 sw 0xDEAD_BEEF at 0x80 -> mem_we in the cycle after accept, resp_valid in the next cycle, and no read cycle.
REQ-040 lw at 0x42 -> resp_err = 1 and no memory access with MISALIGN_TRAP_EN defined; reads word 0x40 without error when undefined. Out-of-range case: lw at 4*MEM_WORDS -> resp_err = 1.
REQ-041 Reset asserted during RD of an sh -> no mem_we, no resp_valid, and req_ready = 1 in the cycle after reset deasserts.
